// File: rtl/epb_serial_tx_if.sv
// Handshake and serial-line bundle for the even-parity serial transmitter.
// The master drives a data word in; the slave answers with ready and the framed line.
interface epb_serial_tx_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              tx;
    logic              par;
    logic              busy;
    logic              frame_done;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  tx,
        input  par,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output tx,
        output par,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/epb_serial_tx.sv
// Even-parity serial transmitter: accepts a word on valid/ready and shifts out
// start, data (LSB first), parity and stop, each held BIT_CYCLES clocks.
module epb_serial_tx #(
    parameter int DATA_W     = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    epb_serial_tx_if.slave bus
);

    localparam int CNT_W = (BIT_CYCLES < 1) ? 1 : $clog2(BIT_CYCLES + 1);
    localparam int IDX_W = (DATA_W < 2) ? 1 : $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              par_q, par_n;
    logic              tx_q, tx_n;
    logic              ready_q, ready_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            par_q   <= par_n;
            tx_q    <= tx_n;
            ready_q <= ready_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Outputs are registered, so they are derived from the next state: the
    // line level seen during a clock is the one chosen at the edge before it.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        par_n   = par_q;
        bit_end = (cnt == CNT_LAST);

        case (state)
            IDLE: begin
                if (bus.din_valid && ready_q) begin
                    shreg_n = bus.din;
                    par_n   = ^bus.din;
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shreg_n = shreg >> 1;
                    if (idx == IDX_LAST) begin
                        state_n = PARITY;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = IDLE;
            end
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase

        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == STOP) && (cnt_n == CNT_LAST);
    end

    assign bus.tx         = tx_q;
    assign bus.par        = par_q;
    assign bus.din_ready  = ready_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_epb_serial_tx.sv
// Self-checking bench for epb_serial_tx: a vector table of frames plus
// back-to-back, held-bit and mid-frame reset sequences, checked per clock.
module tb_epb_serial_tx;

    logic clk;
    logic rst_n;

    epb_serial_tx_if #(.DATA_W(4)) if1 ();
    epb_serial_tx_if #(.DATA_W(4)) if3 ();

    epb_serial_tx #(.DATA_W(4), .BIT_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    epb_serial_tx #(.DATA_W(4), .BIT_CYCLES(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic busy;
        logic ready;
        logic fd;
        logic par;
    } sb_t;

    typedef struct {
        logic [3:0] din;
        logic [6:0] bits;
        logic       par;
    } vec_t;

    sb_t        sbq[$];
    vec_t       vecs[6];
    int         checks;
    int         errors;
    logic [6:0] rxBits;
    int         rxIdx;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushFrame(input logic [6:0] bits, input logic p, input int bc);
        sb_t e;
        for (int k = 0; k < 7; k++) begin
            for (int c = 0; c < bc; c++) begin
                e.tx    = bits[k];
                e.busy  = 1'b1;
                e.ready = 1'b0;
                e.fd    = (k == 6) && (c == bc - 1);
                e.par   = p;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic pushIdle(input logic p);
        sb_t e;
        e.tx    = 1'b1;
        e.busy  = 1'b0;
        e.ready = 1'b1;
        e.fd    = 1'b0;
        e.par   = p;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input int sel, input logic [3:0] d, input logic hold);
        @(negedge clk);
        if (sel == 1) begin
            if1.din       = d;
            if1.din_valid = 1'b1;
        end else begin
            if3.din       = d;
            if3.din_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (sel == 1) if1.din_valid = 1'b0;
            else          if3.din_valid = 1'b0;
        end
    endtask

    task automatic checkOutput(input int sel, input int n);
        sb_t e;
        sb_t a;
        for (int i = 0; i < n; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
            e = sbq.pop_front();
            if (sel == 1) a = '{if1.tx, if1.busy, if1.din_ready, if1.frame_done, if1.par};
            else          a = '{if3.tx, if3.busy, if3.din_ready, if3.frame_done, if3.par};
            checkVal("tx",         32'(a.tx),    32'(e.tx));
            checkVal("busy",       32'(a.busy),  32'(e.busy));
            checkVal("din_ready",  32'(a.ready), 32'(e.ready));
            checkVal("frame_done", 32'(a.fd),    32'(e.fd));
            checkVal("par",        32'(a.par),   32'(e.par));
            if (rxIdx < 7) rxBits[rxIdx[2:0]] = a.tx;
            rxIdx++;
        end
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, "_tx"},         32'(if1.tx),         32'd1);
        checkVal({tag, "_din_ready"},  32'(if1.din_ready),  32'd1);
        checkVal({tag, "_busy"},       32'(if1.busy),       32'd0);
        checkVal({tag, "_par"},        32'(if1.par),        32'd0);
        checkVal({tag, "_frame_done"}, 32'(if1.frame_done), 32'd0);
        checkVal({tag, "_tx3"},        32'(if3.tx),         32'd1);
        checkVal({tag, "_din_ready3"}, 32'(if3.din_ready),  32'd1);
    endtask

    task automatic runVector(input vec_t v);
        applyStimulus(1, v.din, 1'b0);
        pushFrame(v.bits, v.par, 1);
        pushIdle(v.par);
        rxIdx  = 0;
        rxBits = '0;
        checkOutput(1, 100);
        checkVal("rx_data", 32'(rxBits[4:1]), 32'(v.din));
        checkVal("rx_parity_xor", 32'(^rxBits[5:1]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rxIdx  = 0;
        rxBits = '0;

        // Frame bits indexed by position k: bit 0 is start, bit 6 is stop.
        vecs[0] = '{4'b1011, 7'b1110110, 1'b1};
        vecs[1] = '{4'b0000, 7'b1000000, 1'b0};
        vecs[2] = '{4'b1111, 7'b1011110, 1'b0};
        vecs[3] = '{4'b0001, 7'b1100010, 1'b1};
        vecs[4] = '{4'b0110, 7'b1001100, 1'b0};
        vecs[5] = '{4'b1000, 7'b1110000, 1'b1};

        rst_n         = 1'b0;
        if1.din       = '0;
        if1.din_valid = 1'b0;
        if3.din       = '0;
        if3.din_valid = 1'b0;
        #12;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            runVector(vecs[i]);
        end

        // din_valid held high, din changed mid-frame; second word follows
        // exactly one idle clock after frame_done.
        applyStimulus(1, 4'hA, 1'b1);
        pushFrame(7'b1010100, 1'b0, 1);
        pushIdle(1'b0);
        pushFrame(7'b1001010, 1'b0, 1);
        pushIdle(1'b0);
        rxIdx = 0;
        checkOutput(1, 3);
        if1.din = 4'h5;
        checkOutput(1, 5);
        checkVal("b2b_first_word", 32'(rxBits[4:1]), 32'hA);
        @(posedge clk);
        #1;
        if1.din_valid = 1'b0;
        rxIdx = 0;
        checkOutput(1, 8);
        checkVal("b2b_second_word", 32'(rxBits[4:1]), 32'h5);

        // Each bit held three clocks on the slower instance.
        applyStimulus(3, 4'b0110, 1'b0);
        pushFrame(7'b1001100, 1'b0, 3);
        pushIdle(1'b0);
        checkOutput(3, 100);

        // Reset during the DATA state abandons the frame immediately.
        applyStimulus(1, 4'b1011, 1'b0);
        pushFrame(7'b1110110, 1'b1, 1);
        checkOutput(1, 3);
        rst_n = 1'b0;
        #1;
        checkReset("midreset");
        sbq.delete();
        @(negedge clk);
        checkReset("midreset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        runVector(vecs[3]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/epb_serial_tx.md
# epb_serial_tx

Serial transmitter for the 4-bit even-parity link. Accepts a data nibble on a valid/ready handshake and computes the even parity bit, so that data XOR parity is 0. It then shifts out a framed serial word LSB-first: start, data, parity, stop. It sits at the sending end of the link. The receiving end recovers `a,b,c,d,p` and flags an error when the XOR of all five bits is 1.

## Interface
- `DATA_W`, default 4: data bits per frame.
- `BIT_CYCLES`, default 1: clocks each serial bit is held. Legal range is 1..255.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `din` in DATA_W: data word. Sampled only on an accepted handshake.
- `din_valid` in 1: `din` is presented.
- `din_ready` out 1: block can accept a word. Registered.
- `tx` out 1: serial line. Idle level is 1. Registered.
- `par` out 1: parity bit of the word currently being sent. Registered.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-clock pulse in the last clock of the stop bit.

## Operation
- Reset values: `tx`=1, `din_ready`=1, `busy`=0, `par`=0, `frame_done`=0. State is IDLE; bit counter and cycle counter are 0.
- Asserting `rst_n` low forces the reset values immediately. This applies at any point, including mid-frame. The partial frame is abandoned and is not resumed.
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1, `din_ready`=1, `busy`=0.
  - On `din_valid && din_ready` at a rising edge: capture `din` into the shift register, set `par` = ^`din`, and go to START.
- START: `tx`=0 for BIT_CYCLES clocks, then DATA with bit index 0.
- DATA:
  - `tx` = shift-register bit 0 for BIT_CYCLES clocks.
  - Then shift right and increment the index.
  - After index DATA_W-1 completes, go to PARITY.
- PARITY: `tx`=`par` for BIT_CYCLES clocks, then STOP.
- STOP: `tx`=1 for BIT_CYCLES clocks. `frame_done`=1 in the final clock. Then IDLE.
- In every state except IDLE: `din_ready`=0 and `busy`=1.
- Changes on `din`/`din_valid` while busy are ignored. The captured word is never modified mid-frame.
- `din_valid` is allowed to stay high continuously. A new word is accepted on the first IDLE clock after STOP.
- Cycle counter width is ceil(log2(BIT_CYCLES+1)). It counts 0..BIT_CYCLES-1 and wraps to 0 on each bit boundary. With BIT_CYCLES=1 every bit lasts exactly one clock.
- `par` holds its value after the frame ends until the next accept.

## Timing
- Accept edge is T0. `tx` goes 0 (start) in the clock following T0.
- Bit k of the frame occupies clocks T0+1+k·BIT_CYCLES through T0+(k+1)·BIT_CYCLES:
  - k=0: start
  - k=1..DATA_W: data LSB first
  - k=DATA_W+1: parity
  - k=DATA_W+2: stop
- Frame length is (DATA_W+3)·BIT_CYCLES clocks.
- `din_ready` returns to 1 in the clock after `frame_done`.
- Minimum accept-to-accept spacing is (DATA_W+3)·BIT_CYCLES+1 clocks.
- `tx` is glitch-free because it is a direct register output.

## Test plan
- **Basic frame, default parameters.** Accept `din`=4'b1011.
  - `tx` over 7 clocks: 0,1,1,0,1,1,1.
  - `par`=1 and `frame_done` pulses in clock 7.
  - The receiver sees `a,b,c,d,p` = d0..d3 and parity, and XOR of all five is 0.
- **All-zero word.** `din`=4'b0000 gives `tx`: 0,0,0,0,0,0,1 with `par`=0.
- **All-ones word.** `din`=4'b1111 gives `tx`: 0,1,1,1,1,0,1 with `par`=0.
- **Held bits.** With BIT_CYCLES=3, `din`=4'b0110 gives each of 0,0,1,1,0,0,1 held exactly 3 clocks. Frame is 21 clocks and `din_ready` is 0 throughout.
- **Back-to-back with input changing.** Hold `din_valid`=1 and change `din` from 4'hA to 4'h5 mid-frame.
  - The first frame sends 0,0,1,0,1,0,1 unaltered.
  - The second word (4'h5) is accepted exactly 1 clock after `frame_done`.
- **Reset mid-frame.** Drop `rst_n` during the DATA state of 4'b1011.
  - `tx`=1, `busy`=0 and `din_ready`=1 take effect before the next edge.
  - After release, a fresh 4'b0001 sends 0,1,0,0,0,1,1.
